// File: rtl/pipe_front_regs_if.sv
// Instruction-memory fetch bus between the front end and imem.
// The front end presents the address; imem answers with data and valid.
interface pipe_front_regs_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage RV32I core.
// Applies hazard stalls/flushes and turns imem wait states into bubbles.
module pipe_front_regs #(
    parameter int             XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]    NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            flushD,
    input  logic            flushE,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] pc_targetE,
    pipe_front_regs_if.master imem,
    output logic [XLEN-1:0] pcF,
    output logic [31:0]     instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pc_plus4D,
    output logic            validD,
    output logic [4:0]      rs1D,
    output logic [4:0]      rs2D,
    output logic [4:0]      rdD,
    input  logic            reg_writeD,
    input  logic            result_selD,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E,
    output logic [4:0]      rdE,
    output logic [XLEN-1:0] pcE,
    output logic [XLEN-1:0] pc_plus4E,
    output logic            reg_writeE,
    output logic            result_selE,
    output logic            validE,
    output logic [15:0]     bubble_cnt
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } d_t;

    typedef struct packed {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            reg_write;
        logic            result_sel;
        logic            valid;
    } e_t;

    localparam d_t D_BUBBLE = '{instr: NOP, pc: '0, pc4: '0, valid: 1'b0};

    logic [XLEN-1:0] pc_q, pc_d;
    d_t              d_q, d_d;
    e_t              e_q, e_d;
    logic [15:0]     cnt_q, cnt_d;

    always_comb begin
        pc_d  = pc_q;
        d_d   = d_q;
        e_d   = e_q;
        cnt_d = cnt_q;
        if (rst) begin
            pc_d  = RESET_PC;
            d_d   = D_BUBBLE;
            e_d   = '0;
            cnt_d = '0;
        end else begin
            // A redirect also abandons any fetch still waiting on imem.
            if (pc_sel)
                pc_d = pc_targetE;
            else if (!stallF && imem.imem_valid)
                pc_d = pc_q + XLEN'(4);

            if (flushD)
                d_d = D_BUBBLE;
            else if (stallD)
                d_d = d_q;
            else if (!imem.imem_valid)
                d_d = D_BUBBLE;
            else
                d_d = '{instr: imem.imem_rdata, pc: pc_q,
                        pc4: pc_q + XLEN'(4), valid: 1'b1};

            if (flushE) begin
                e_d = '0;
            end else begin
                e_d.rs1        = d_q.instr[19:15];
                e_d.rs2        = d_q.instr[24:20];
                e_d.rd         = d_q.instr[11:7];
                e_d.pc         = d_q.pc;
                e_d.pc4        = d_q.pc4;
                e_d.reg_write  = reg_writeD & d_q.valid;
                e_d.result_sel = result_selD & d_q.valid;
                e_d.valid      = d_q.valid;
            end

            if (!e_d.valid && cnt_q != 16'hFFFF)
                cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        pc_q  <= pc_d;
        d_q   <= d_d;
        e_q   <= e_d;
        cnt_q <= cnt_d;
    end

    assign imem.imem_addr = pc_q;
    assign pcF            = pc_q;
    assign instrD         = d_q.instr;
    assign pcD            = d_q.pc;
    assign pc_plus4D      = d_q.pc4;
    assign validD         = d_q.valid;
    assign rs1D           = d_q.instr[19:15];
    assign rs2D           = d_q.instr[24:20];
    assign rdD            = d_q.instr[11:7];
    assign rs1E           = e_q.rs1;
    assign rs2E           = e_q.rs2;
    assign rdE            = e_q.rd;
    assign pcE            = e_q.pc;
    assign pc_plus4E      = e_q.pc4;
    assign reg_writeE     = e_q.reg_write;
    assign result_selE    = e_q.result_sel;
    assign validE         = e_q.valid;
    assign bubble_cnt     = cnt_q;

    // ID/EX cannot stall, so a held D slot must be squashed out of E.
    a_stall_needs_flush : assert property (
        @(posedge clk) disable iff (rst)
        (stallD && !pc_sel) |-> flushE
    );

endmodule
